// File: rtl/cvxif_pkg.sv
// Shared CVXIF types: convolution layer descriptor plus the constants and
// state enum used by the weights SRAM writer.
package cvxif_pkg;

    localparam int KERNEL_ELEMS = 9;
    localparam int BYTE_LANES   = 4;
    localparam int LANE_W       = $clog2(BYTE_LANES);

    typedef enum logic [0:0] {
        IDLE,
        RUN
    } wsw_state_e;

    typedef struct packed {
        logic [7:0] W_in;
        logic [7:0] H_in;
        logic [7:0] C_in;
        logic [7:0] W_kernels;
        logic [1:0] stride;
        logic [1:0] padding;
    } convolution;

endpackage

// File: rtl/weights_sram_writer_packer.sv
// Byte lane packer: accumulates weight bytes into one SRAM word with pending
// byte enables; the merged view includes the byte being pushed this cycle.
module byte_lane_packer
    import cvxif_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    push,
    input  logic [LANE_W-1:0]       lane,
    input  logic [7:0]              wt_byte,
    input  logic                    flush,
    output logic [BYTE_LANES*8-1:0] word,
    output logic [BYTE_LANES-1:0]   be
);

    logic [BYTE_LANES*8-1:0] word_q;
    logic [BYTE_LANES-1:0]   be_q;

    always_comb begin
        word = word_q;
        be   = be_q;
        if (push) begin
            word[{lane, 3'b000} +: 8] = wt_byte;
            be[lane]                  = 1'b1;
        end
    end

    // A flush hands the merged word out and restarts from an all-zero word.
    always_ff @(posedge i_clk) begin
        if (i_rst || flush) begin
            word_q <= '0;
            be_q   <= '0;
        end else if (push) begin
            word_q <= word;
            be_q   <= be;
        end
    end

endmodule

// File: rtl/weights_sram_writer.sv
// Weights SRAM writer: packs a per-channel int8 weight stream four bytes per
// word and writes it at the channel's byte offset in the weights SRAM.
module weights_sram_writer
    import cvxif_pkg::*;
#(
    parameter int ADR_W  = 16,
    parameter int SRAM_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  convolution            data,
    input  logic                  i_start,
    input  logic [6:0]            i_ch,
    input  logic                  i_wt_valid,
    input  logic [7:0]            i_wt_data,
    output logic                  o_wt_ready,
    output logic [ADR_W-1:0]      o_sram_addr,
    output logic                  o_sram_wren,
    output logic [SRAM_W-1:0]     o_sram_wdata,
    output logic [BYTE_LANES-1:0] o_sram_be,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int CW = ADR_W + 2;

    wsw_state_e              state_q, state_d;
    logic [CW-1:0]           bp_q, bp_d;
    logic [CW-1:0]           n_q, n_d;
    logic [CW-1:0]           start_n, start_bp;
    logic                    busy_d, done_d;
    logic                    fire, last, flush;
    logic [LANE_W-1:0]       lane;
    logic [BYTE_LANES*8-1:0] pk_word;
    logic [BYTE_LANES-1:0]   pk_be;
    logic                    unused_data;

    assign unused_data = ^{data.W_in, data.H_in, data.C_in, data.stride, data.padding};

    assign start_n  = CW'(data.W_kernels) * CW'(KERNEL_ELEMS);
    assign start_bp = (CW'(i_ch) - CW'(1)) * start_n;

    assign fire  = (state_q == RUN) && i_wt_valid;
    assign lane  = bp_q[LANE_W-1:0];
    assign last  = (n_q == CW'(1));
    assign flush = fire && ((lane == LANE_W'(BYTE_LANES - 1)) || last);

    always_comb begin
        state_d    = state_q;
        bp_d       = bp_q;
        n_d        = n_q;
        busy_d     = o_busy;
        done_d     = 1'b0;
        o_wt_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start && (i_ch != '0)) begin
                    bp_d = start_bp;
                    n_d  = start_n;
                    // An empty kernel set completes immediately without a write.
                    if (start_n == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                o_wt_ready = 1'b1;
                if (fire) begin
                    bp_d = bp_q + CW'(1);
                    n_d  = n_q - CW'(1);
                    if (last) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    byte_lane_packer u_packer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .push    (fire),
        .lane    (lane),
        .wt_byte (i_wt_data),
        .flush   (flush),
        .word    (pk_word),
        .be      (pk_be)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            bp_q         <= '0;
            n_q          <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_sram_wren  <= 1'b0;
            o_sram_addr  <= '0;
            o_sram_wdata <= '0;
            o_sram_be    <= '0;
        end else begin
            state_q     <= state_d;
            bp_q        <= bp_d;
            n_q         <= n_d;
            o_busy      <= busy_d;
            o_done      <= done_d;
            o_sram_wren <= flush;
            // Address is taken from the pointer before increment: the flushed byte's word.
            if (flush) begin
                o_sram_addr  <= bp_q[CW-1:LANE_W];
                o_sram_wdata <= pk_word;
                o_sram_be    <= pk_be;
            end
        end
    end

endmodule

// File: tb/tb_weights_sram_writer.sv
// Self-checking bench for weights_sram_writer: table vectors, randomized loads
// against a byte-map reference model, and hand-written corner sequences.
module tb_weights_sram_writer;
    import cvxif_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    convolution  data;
    logic        start;
    logic [6:0]  ch;
    logic        wt_valid;
    logic [7:0]  wt_data;
    logic        wt_ready;
    logic [15:0] sram_addr;
    logic        sram_wren;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_be;
    logic        busy;
    logic        done;

    weights_sram_writer #(.ADR_W(16), .SRAM_W(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .data         (data),
        .i_start      (start),
        .i_ch         (ch),
        .i_wt_valid   (wt_valid),
        .i_wt_data    (wt_data),
        .o_wt_ready   (wt_ready),
        .o_sram_addr  (sram_addr),
        .o_sram_wren  (sram_wren),
        .o_sram_wdata (sram_wdata),
        .o_sram_be    (sram_be),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          k;
        int          chn;
        logic [7:0]  b0;
        int          gap;
        int          nwr;
        logic [15:0] a0;
        logic [3:0]  be0;
        logic [31:0] d0;
        logic [15:0] a_l;
        logic [3:0]  be_l;
        logic [31:0] d_l;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          done_cnt, done_nowr, busy_low;
    logic [15:0] got_addr[$];
    logic [3:0]  got_be[$];
    logic [31:0] got_data[$];
    logic        got_done[$];
    logic [15:0] exp_addr[$];
    logic [3:0]  exp_be[$];
    logic [31:0] exp_data[$];
    logic [7:0]  stream[$];
    vec_t        vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (sram_wren === 1'b1) begin
            got_addr.push_back(sram_addr);
            got_be.push_back(sram_be);
            got_data.push_back(sram_wdata);
            got_done.push_back(done);
        end
        if (done === 1'b1) begin
            done_cnt++;
            if (sram_wren !== 1'b1) done_nowr++;
        end
    endtask

    task automatic clear_mon();
        got_addr.delete();
        got_be.delete();
        got_data.delete();
        got_done.delete();
        done_cnt  = 0;
        done_nowr = 0;
        busy_low  = 0;
    endtask

    // Reference: place every byte at its absolute byte address, group by word.
    task automatic build_model(input int k, input int chn);
        logic [31:0] wd[int];
        logic [3:0]  wb[int];
        int          order[$];
        logic [31:0] td;
        logic [3:0]  tb4;
        int          base;
        base = (chn - 1) * KERNEL_ELEMS * k;
        exp_addr.delete();
        exp_be.delete();
        exp_data.delete();
        for (int i = 0; i < KERNEL_ELEMS * k; i++) begin
            int b;
            int w;
            int l;
            b = base + i;
            w = (b / 4) % 65536;
            l = b % 4;
            if (!wb.exists(w)) begin
                order.push_back(w);
                wb[w] = '0;
                wd[w] = '0;
            end
            tb4 = wb[w];
            td  = wd[w];
            tb4[l] = 1'b1;
            td[8*l +: 8] = stream[i];
            wb[w] = tb4;
            wd[w] = td;
        end
        foreach (order[j]) begin
            exp_addr.push_back(16'(order[j]));
            exp_be.push_back(wb[order[j]]);
            exp_data.push_back(wd[order[j]]);
        end
    endtask

    task automatic compare_model(input string name);
        check({name, "_nwr"}, 64'(got_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
            check({name, "_wr"}, {got_addr[i], got_be[i], got_data[i]},
                  {exp_addr[i], exp_be[i], exp_data[i]});
        check({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check({name, "_done_nowr"}, 64'(done_nowr), 64'd0);
        if (got_done.size() > 0)
            check({name, "_done_last"}, 64'(got_done[got_done.size()-1]), 64'd1);
        check({name, "_busy_held"}, 64'(busy_low), 64'd0);
    endtask

    task automatic do_load(input int k, input int chn, input int gap_mode, input int mid_start);
        int   idx;
        int   t;
        int   n;
        logic v;
        idx = 0;
        t   = 0;
        n   = KERNEL_ELEMS * k;
        clear_mon();
        data.W_kernels = 8'(k);
        ch    = 7'(chn);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_ready_after_start", {62'd0, busy, wt_ready}, 64'd3);
        while (idx < n && t < 4000) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (t % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            wt_valid = v;
            wt_data  = v ? stream[idx] : 8'($urandom);
            if (idx == mid_start) begin
                start = 1'b1;
                ch    = 7'd3;
            end else begin
                start = 1'b0;
            end
            if (v && wt_ready) idx++;
            tick();
            if (idx < n && busy !== 1'b1) busy_low++;
            t++;
        end
        wt_valid = 1'b0;
        start    = 1'b0;
        check("stream_consumed", 64'(idx), 64'(n));
        repeat (4) tick();
        check("idle_after_load", {62'd0, busy, wt_ready}, 64'd0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {wt_ready, sram_wren, sram_addr, sram_wdata, sram_be, busy, done}, 64'd0);
    endtask

    initial begin
        int idx;
        int t;
        vecs[0] = '{4, 1, 8'h00, 0, 9, 16'd0, 4'hF,    32'h03020100, 16'd8,  4'hF,    32'h23222120};
        vecs[1] = '{1, 2, 8'hA0, 0, 3, 16'd2, 4'b1110, 32'hA2A1A000, 16'd4,  4'b0011, 32'h0000A8A7};
        vecs[2] = '{4, 1, 8'h00, 1, 9, 16'd0, 4'hF,    32'h03020100, 16'd8,  4'hF,    32'h23222120};
        vecs[3] = '{2, 3, 8'h10, 2, 5, 16'd9, 4'hF,    32'h13121110, 16'd13, 4'b0011, 32'h00002120};

        rst      = 1'b1;
        data     = '0;
        start    = 1'b0;
        ch       = '0;
        wt_valid = 1'b0;
        wt_data  = '0;
        clear_mon();
        repeat (3) tick();
        check_all_zero("reset_outputs");
        rst = 1'b0;
        tick();

        foreach (vecs[v]) begin
            stream.delete();
            for (int i = 0; i < KERNEL_ELEMS * vecs[v].k; i++) stream.push_back(8'(vecs[v].b0 + i));
            build_model(vecs[v].k, vecs[v].chn);
            do_load(vecs[v].k, vecs[v].chn, vecs[v].gap, -1);
            check("vec_nwr", 64'(got_addr.size()), 64'(vecs[v].nwr));
            if (got_addr.size() > 0) begin
                check("vec_first", {got_addr[0], got_be[0], got_data[0]},
                      {vecs[v].a0, vecs[v].be0, vecs[v].d0});
                check("vec_last", {got_addr[got_addr.size()-1], got_be[got_be.size()-1],
                                   got_data[got_data.size()-1]},
                      {vecs[v].a_l, vecs[v].be_l, vecs[v].d_l});
            end
            compare_model("vec_model");
        end

        for (int r = 0; r < 6; r++) begin
            int k;
            int c;
            k = int'($urandom_range(1, 5));
            c = int'($urandom_range(1, 127));
            stream.delete();
            for (int i = 0; i < KERNEL_ELEMS * k; i++) stream.push_back(8'($urandom));
            build_model(k, c);
            do_load(k, c, 2, -1);
            compare_model("rand_model");
        end

        stream.delete();
        for (int i = 0; i < 36; i++) stream.push_back(8'(i));
        build_model(4, 1);
        do_load(4, 1, 0, 10);
        compare_model("mid_start");

        clear_mon();
        data.W_kernels = 8'd4;
        ch    = 7'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        idx = 0;
        t   = 0;
        while (idx < 6 && t < 100) begin
            wt_valid = 1'b1;
            wt_data  = stream[idx];
            if (wt_ready) idx++;
            tick();
            t++;
        end
        wt_valid = 1'b0;
        rst      = 1'b1;
        tick();
        check_all_zero("rst_mid_run_outputs");
        rst = 1'b0;
        repeat (5) tick();
        check("rst_mid_run_nwr", 64'(got_addr.size()), 64'd1);
        if (got_addr.size() > 0)
            check("rst_mid_run_wr", {got_addr[0], got_be[0], got_data[0]},
                  {16'd0, 4'hF, 32'h03020100});
        check("rst_mid_run_done", 64'(done_cnt), 64'd0);

        stream.delete();
        for (int i = 0; i < 9; i++) stream.push_back(8'(8'hC0 + i));
        build_model(1, 2);
        do_load(1, 2, 0, -1);
        compare_model("after_rst_load");

        clear_mon();
        data.W_kernels = 8'd0;
        ch    = 7'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("k0_done_busy", {62'd0, done, busy}, 64'd2);
        tick();
        check("k0_done_pulse", 64'(done), 64'd0);
        repeat (3) tick();
        check("k0_no_write", 64'(got_addr.size()), 64'd0);
        check("k0_done_cnt", 64'(done_cnt), 64'd1);

        clear_mon();
        data.W_kernels = 8'd4;
        ch    = 7'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ch0_idle", {62'd0, busy, wt_ready}, 64'd0);
        repeat (3) tick();
        check("ch0_busy_low", 64'(busy), 64'd0);
        check("ch0_no_activity", 64'(got_addr.size() + done_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
